mc_ctrl_fsm: RTL and testbench

- Multi-cycle main controller for the RV32I datapath. It sequences fetch, decode, execute, memory and writeback over a shared ALU and a single memory port.
- Generates the 2-bit ALU_Op consumed by the ALU control decoder: 00 = ADD, 01 = SUB, 10 = R-type funct decode, 11 = I-type funct decode.
- Sits between the instruction register and the datapath mux/enable controls.
- Drives a req/ready handshake toward unified instruction/data memory.

---
 rtl/mc_ctrl_fsm_pkg.sv | 58 +++++
 rtl/mc_op_class.sv | 29 ++
 rtl/mc_ctrl_fsm.sv | 203 ++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_fsm_pkg.sv
// mc_ctrl_fsm_pkg: shared definitions for the RV32I multi-cycle controller.
// Holds the opcode values, controller state encoding, ALU_Op classes, mux
// select encodings and the one-hot instruction class record.
package mc_ctrl_fsm_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [1:0] SRCA_RS1  = 2'b00;
  localparam logic [1:0] SRCA_PC   = 2'b01;
  localparam logic [1:0] SRCA_ZERO = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic PC_PLUS4  = 1'b0;
  localparam logic PC_TARGET = 1'b1;

  typedef struct packed {
    logic r;
    logic ialu;
    logic load;
    logic store;
    logic branch;
    logic jal;
    logic jalr;
    logic lui;
    logic auipc;
  } op_class_t;

endpackage

// File: rtl/mc_op_class.sv
// mc_op_class: combinational opcode classifier.
// Ports: opcode (instr[6:0]) in; cls one-hot class record out; illegal high
// when the opcode matches none of the nine supported classes.
module mc_op_class
  import mc_ctrl_fsm_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_t  cls,
  output logic       illegal
);

  always_comb begin
    cls = '0;
    case (opcode)
      OP_R:      cls.r      = 1'b1;
      OP_IALU:   cls.ialu   = 1'b1;
      OP_LOAD:   cls.load   = 1'b1;
      OP_STORE:  cls.store  = 1'b1;
      OP_BRANCH: cls.branch = 1'b1;
      OP_JAL:    cls.jal    = 1'b1;
      OP_JALR:   cls.jalr   = 1'b1;
      OP_LUI:    cls.lui    = 1'b1;
      OP_AUIPC:  cls.auipc  = 1'b1;
      default:   cls = '0;
    endcase
    illegal = (cls == '0);
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle RV32I main controller (IDLE/FETCH/DECODE/EXEC/
// MEM/WB/TRAP) driving datapath mux/enable controls and a req/ready port to
// unified memory.
// Ports: clk, rst_n (async, active-low), instr, br_taken, mem_ready, halt in;
// ALU_Op, alu_src_a, alu_src_b, pc_write, pc_src, ir_write, mem_req, mem_we,
// mem_addr_sel, reg_write, wb_sel, instr_done, illegal out.
// Optional: define MC_CTRL_PERF_EN to add perf_cycles, perf_retired and
// perf_stall 32-bit wrapping counters.
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
#(
  parameter int unsigned RESET_PC_HOLD = 1
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        br_taken,
  input  logic        mem_ready,
  input  logic        halt,
  output logic [1:0]  ALU_Op,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        pc_write,
  output logic        pc_src,
  output logic        ir_write,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        instr_done,
  output logic        illegal
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0] perf_cycles,
  output logic [31:0] perf_retired,
  output logic [31:0] perf_stall
`endif
);

  localparam logic [3:0] HOLD_LAST = 4'(RESET_PC_HOLD - 1);

  state_t     state, state_nxt;
  logic [3:0] hold_cnt, hold_cnt_nxt;
  logic       fetch_busy, fetch_busy_nxt;
  op_class_t  cls;
  logic       op_illegal;
  logic [1:0] op_aluop, op_srca, op_srcb, op_wbsel;
  logic       unused_instr;

  assign unused_instr = ^instr[31:7];

  mc_op_class u_op_class (
    .opcode  (instr[6:0]),
    .cls     (cls),
    .illegal (op_illegal)
  );

  // Per-class ALU setup; driven in EXEC and held through MEM/WB so the ALU
  // result (address or writeback value) stays stable.
  always_comb begin
    op_aluop = ALUOP_ADD;
    op_srca  = SRCA_RS1;
    op_srcb  = SRCB_IMM;
    op_wbsel = WB_ALU;
    if (cls.r) begin
      op_aluop = ALUOP_RTYPE;
      op_srcb  = SRCB_RS2;
    end
    if (cls.ialu)             op_aluop = ALUOP_ITYPE;
    if (cls.branch) begin
      op_aluop = ALUOP_SUB;
      op_srcb  = SRCB_RS2;
    end
    if (cls.jal || cls.auipc) op_srca  = SRCA_PC;
    if (cls.lui)              op_srca  = SRCA_ZERO;
    if (cls.jal || cls.jalr)  op_wbsel = WB_PC4;
    if (cls.load)             op_wbsel = WB_MEM;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      hold_cnt   <= '0;
      fetch_busy <= 1'b0;
    end else begin
      state      <= state_nxt;
      hold_cnt   <= hold_cnt_nxt;
      fetch_busy <= fetch_busy_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    hold_cnt_nxt   = hold_cnt;
    fetch_busy_nxt = 1'b0;
    ALU_Op         = '0;
    alu_src_a      = '0;
    alu_src_b      = '0;
    pc_write       = 1'b0;
    pc_src         = PC_PLUS4;
    ir_write       = 1'b0;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    mem_addr_sel   = 1'b0;
    reg_write      = 1'b0;
    wb_sel         = '0;
    instr_done     = 1'b0;
    illegal        = 1'b0;

    case (state)
      ST_IDLE: begin
        if (hold_cnt == HOLD_LAST) begin
          state_nxt    = ST_FETCH;
          hold_cnt_nxt = '0;
        end else begin
          hold_cnt_nxt = hold_cnt + 4'd1;
        end
      end
      ST_FETCH: begin
        // fetch_busy marks a request already on the bus; halt only gates
        // the first request cycle, never an outstanding one.
        if (fetch_busy || !halt) begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write  = 1'b1;
            pc_write  = 1'b1;
            state_nxt = ST_DECODE;
          end else begin
            fetch_busy_nxt = 1'b1;
          end
        end
      end
      ST_DECODE: begin
        state_nxt = op_illegal ? ST_TRAP : ST_EXEC;
      end
      ST_EXEC: begin
        ALU_Op    = op_aluop;
        alu_src_a = op_srca;
        alu_src_b = op_srcb;
        if (cls.branch) begin
          pc_write   = br_taken;
          pc_src     = br_taken ? PC_TARGET : PC_PLUS4;
          instr_done = 1'b1;
          state_nxt  = ST_FETCH;
        end else if (cls.load || cls.store) begin
          state_nxt = ST_MEM;
        end else begin
          if (cls.jal || cls.jalr) begin
            pc_write = 1'b1;
            pc_src   = PC_TARGET;
          end
          state_nxt = ST_WB;
        end
      end
      ST_MEM: begin
        ALU_Op       = op_aluop;
        alu_src_a    = op_srca;
        alu_src_b    = op_srcb;
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = cls.store;
        if (mem_ready) begin
          if (cls.store) begin
            instr_done = 1'b1;
            state_nxt  = ST_FETCH;
          end else begin
            state_nxt = ST_WB;
          end
        end
      end
      ST_WB: begin
        ALU_Op     = op_aluop;
        alu_src_a  = op_srca;
        alu_src_b  = op_srcb;
        reg_write  = 1'b1;
        wb_sel     = op_wbsel;
        instr_done = 1'b1;
        state_nxt  = ST_FETCH;
      end
      ST_TRAP: begin
        illegal = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef MC_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles  <= '0;
      perf_retired <= '0;
      perf_stall   <= '0;
    end else begin
      if (state != ST_IDLE)      perf_cycles  <= perf_cycles + 32'd1;
      if (instr_done)            perf_retired <= perf_retired + 32'd1;
      if (mem_req && !mem_ready) perf_stall   <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: self-checking bench for mc_ctrl_fsm (default build).
// Expected per-cycle outputs are generated from each instruction's class,
// memory wait counts and branch outcome, then compared every cycle.
module tb_mc_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic        br_taken = 1'b0;
  logic        mem_ready = 1'b0;
  logic        halt = 1'b0;
  logic [1:0]  ALU_Op, alu_src_a, alu_src_b, wb_sel;
  logic        pc_write, pc_src, ir_write, mem_req, mem_we, mem_addr_sel;
  logic        reg_write, instr_done, illegal;

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.RESET_PC_HOLD(1)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .br_taken(br_taken),
    .mem_ready(mem_ready), .halt(halt), .ALU_Op(ALU_Op),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_write(pc_write),
    .pc_src(pc_src), .ir_write(ir_write), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .reg_write(reg_write), .wb_sel(wb_sel),
    .instr_done(instr_done), .illegal(illegal)
  );

  typedef struct packed {
    logic [1:0] aluop, srca, srcb;
    logic pc_write, pc_src, ir_write, mem_req, mem_we, mem_addr_sel, reg_write;
    logic [1:0] wb_sel;
    logic instr_done, illegal;
  } outs_t;

  typedef struct packed {
    logic legal, load, store, branch, jump;
    logic [1:0] aluop, srca, srcb, wbsel;
  } cls_t;

  outs_t got;
  outs_t zero_o = '0;
  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [6:0] legal_ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011,
                                7'b0100011, 7'b1100011, 7'b1101111,
                                7'b1100111, 7'b0110111, 7'b0010111};

  assign got = {ALU_Op, alu_src_a, alu_src_b, pc_write, pc_src, ir_write,
                mem_req, mem_we, mem_addr_sel, reg_write, wb_sel, instr_done,
                illegal};

  // Class table: ALU_Op, operand selects and writeback source per opcode.
  function automatic cls_t classify(input logic [6:0] op);
    cls_t c;
    c = '0;
    c.legal = 1'b1;
    case (op)
      7'b0110011: c.aluop = 2'b10;
      7'b0010011: begin c.aluop = 2'b11; c.srcb = 2'b01; end
      7'b0000011: begin c.load = 1'b1; c.srcb = 2'b01; c.wbsel = 2'b01; end
      7'b0100011: begin c.store = 1'b1; c.srcb = 2'b01; end
      7'b1100011: begin c.branch = 1'b1; c.aluop = 2'b01; end
      7'b1101111: begin c.jump = 1'b1; c.srca = 2'b01; c.srcb = 2'b01; c.wbsel = 2'b10; end
      7'b1100111: begin c.jump = 1'b1; c.srcb = 2'b01; c.wbsel = 2'b10; end
      7'b0110111: begin c.srca = 2'b10; c.srcb = 2'b01; end
      7'b0010111: begin c.srca = 2'b01; c.srcb = 2'b01; end
      default:    c.legal = 1'b0;
    endcase
    return c;
  endfunction

  task automatic check(input string tag, input outs_t e);
    @(negedge clk);
    tests++;
    assert (got === e) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    halt = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) check("reset", zero_o);
    rst_n = 1'b1;
    mem_ready = 1'b0;
    check("idle_hold", zero_o);
  endtask

  // Runs one instruction starting at the fetch boundary. hold = halt cycles
  // before the request, fw/mw = not-ready cycles in fetch/memory.
  task automatic run_instr(input logic [31:0] ins, input int unsigned hold,
                           input int unsigned fw, input int unsigned mw,
                           input logic bt);
    cls_t  c;
    outs_t e, base;
    c = classify(ins[6:0]);
    for (int unsigned k = 0; k < hold; k++) begin
      halt = 1'b1; mem_ready = 1'($urandom);
      check("halt_hold", zero_o);
    end
    halt = 1'b0;
    for (int unsigned k = 0; k < fw; k++) begin
      mem_ready = 1'b0;
      e = '0; e.mem_req = 1'b1;
      check("fetch_wait", e);
      halt = 1'($urandom);
    end
    mem_ready = 1'b1;
    instr = ins;
    e = '0; e.mem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
    check("fetch_done", e);
    mem_ready = 1'($urandom); br_taken = 1'($urandom); halt = 1'($urandom);
    check("decode", zero_o);
    if (!c.legal) begin
      e = '0; e.illegal = 1'b1;
      for (int k = 0; k < 10; k++) check("trap", e);
      halt = 1'b0;
      return;
    end
    base = '0; base.aluop = c.aluop; base.srca = c.srca; base.srcb = c.srcb;
    br_taken = bt;
    e = base;
    if (c.branch) begin e.pc_write = bt; e.pc_src = bt; e.instr_done = 1'b1; end
    if (c.jump) begin e.pc_write = 1'b1; e.pc_src = 1'b1; end
    check("exec", e);
    if (c.load || c.store) begin
      e = base; e.mem_req = 1'b1; e.mem_addr_sel = 1'b1; e.mem_we = c.store;
      for (int unsigned k = 0; k < mw; k++) begin
        mem_ready = 1'b0; check("mem_wait", e);
      end
      mem_ready = 1'b1; e.instr_done = c.store;
      check("mem_done", e);
    end
    if (!c.branch && !c.store) begin
      mem_ready = 1'($urandom);
      e = base; e.reg_write = 1'b1; e.instr_done = 1'b1; e.wb_sel = c.wbsel;
      check("wb", e);
    end
    halt = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    outs_t e;
    // Reset, then the directed programme.
    do_reset();
    run_instr(32'h002081B3, 0, 0, 0, 1'b0);
    run_instr(32'h0000A183, 0, 0, 2, 1'b0);
    run_instr(32'h00208463, 0, 0, 0, 1'b1);
    run_instr(32'h00208463, 0, 0, 0, 1'b0);
    run_instr(32'h002081B3, 2, 1, 0, 1'b0);
    run_instr(32'h0000007F, 0, 0, 0, 1'b0);
    do_reset();

    // Store interrupted by reset while waiting in MEM.
    mem_ready = 1'b1; instr = 32'h0030A023;
    e = '0; e.mem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
    check("sw_fetch", e);
    check("sw_decode", zero_o);
    e = '0; e.srcb = 2'b01;
    check("sw_exec", e);
    mem_ready = 1'b0;
    e.mem_req = 1'b1; e.mem_addr_sel = 1'b1; e.mem_we = 1'b1;
    check("sw_mem_wait", e);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    assert (got === zero_o) else begin
      fails++;
      $error("FAIL async_reset: observed %h expected %h", got, zero_o);
    end
    mem_ready = 1'b1;
    @(posedge clk); #1;
    do_reset();

    // Randomised instruction stream.
    for (int n = 0; n < 80; n++) begin
      r = $urandom;
      run_instr({r[31:7], legal_ops[$urandom_range(0, 8)]},
                $urandom_range(0, 2), $urandom_range(0, 2),
                $urandom_range(0, 2), 1'($urandom));
    end
    run_instr(32'hFFFFF07B, 0, 1, 0, 1'b0);
    do_reset();
    run_instr(32'h0000A183, 0, 0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
